// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a one-byte holding register.
// Start bit is re-checked at mid-bit to reject glitches; data and stop bits
// are sampled one bit period apart from that point. A received byte is
// handed to the consumer through o_char/o_valid with an i_ack handshake;
// bytes that arrive before the previous one is acknowledged set o_overrun.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  input  logic       i_ack,
  output logic [7:0] o_char,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_overrun,
  output logic       o_busy
);

  localparam logic [15:0] HALF = 16'(CLKS_PER_BIT / 2);
  localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_e;

  logic       rx_meta_q;
  logic       rx_sync_q;
  logic       rx_prev_q;

  state_e      state_q,  state_d;
  logic [15:0] cnt_q,    cnt_d;
  logic [2:0]  idx_q,    idx_d;
  logic [7:0]  shift_q,  shift_d;
  logic        load_q,   load_d;
  logic        ferr_q,   ferr_d;

  logic [7:0]  char_q,   char_d;
  logic        valid_q,  valid_d;
  logic        ovr_q,    ovr_d;

  // Two-flop synchronizer plus a history flop for falling-edge detection.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

  // Receiver FSM state, bit timer, bit index and shift register.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      load_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      load_q  <= load_d;
      ferr_q  <= ferr_d;
    end
  end

  // Next-state logic: mid-bit start check, then full-period data/stop sampling.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    load_d  = 1'b0;
    ferr_d  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_prev_q && !rx_sync_q) begin
          state_d = START;
          cnt_d   = '0;
        end
      end
      START: begin
        if (cnt_q == HALF) begin
          cnt_d = '0;
          if (!rx_sync_q) begin
            state_d = DATA;
            idx_d   = '0;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          shift_d = {rx_sync_q, shift_q[7:1]};
          cnt_d   = '0;
          idx_d   = idx_q + 3'd1;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          state_d = IDLE;
          cnt_d   = '0;
          if (rx_sync_q) begin
            load_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Consumer-facing holding register, valid flag and sticky overrun.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      char_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      char_q  <= char_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  // A load beats a simultaneous ack; an unacknowledged load flags overrun.
  always_comb begin
    char_d  = char_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (load_q) begin
      char_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !i_ack) begin
        ovr_d = 1'b1;
      end else if (valid_q && i_ack) begin
        ovr_d = 1'b0;
      end
    end else if (valid_q && i_ack) begin
      valid_d = 1'b0;
      ovr_d   = 1'b0;
    end
  end

  assign o_char      = char_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_overrun   = ovr_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames with a scoreboard of expected receive events.
module tb_uart_rx;

  localparam int CPB = 16;

  logic       clk;
  logic       rst_n;
  logic       rx;
  logic       ack;
  logic [7:0] o_char;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_rx       (rx),
    .i_ack      (ack),
    .o_char     (o_char),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_overrun  (o_overrun),
    .o_busy     (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit         is_ferr;
    logic [7:0] data;
    bit         lat_chk;
    int         start_cyc;
  } exp_t;

  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;
  int ferr_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_cond(input string name, input bit ok, input int act, input string req);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got %0d required %s", name, act, req);
    end
  endtask

  // Monitor: pops an expected event whenever the DUT presents a byte or frame error.
  logic       prev_valid = 1'b0;
  logic [7:0] prev_char  = 8'h00;
  logic       prev_ferr  = 1'b0;
  exp_t       mon_e;
  int         mon_lat;

  always @(negedge clk) begin
    if (o_frame_err) ferr_cnt++;
    if (rst_n) begin
      if (o_valid && (!prev_valid || o_char != prev_char)) begin
        if (exp_q.size() == 0) begin
          check_cond("unexpected_byte", 1'b0, int'(o_char), "no byte");
        end else begin
          mon_e = exp_q.pop_front();
          check("event_is_byte", 0, int'(mon_e.is_ferr));
          check("byte_data", int'(o_char), int'(mon_e.data));
          if (mon_e.lat_chk) begin
            mon_lat = cyc - mon_e.start_cyc - 1;
            check_cond("latency", (mon_lat >= 155) && (mon_lat <= 157), mon_lat, "156+-1");
          end
        end
      end
      if (o_frame_err && !prev_ferr) begin
        if (exp_q.size() == 0) begin
          check_cond("unexpected_frame_err", 1'b0, 1, "no frame error");
        end else begin
          mon_e = exp_q.pop_front();
          check("event_is_ferr", 1, int'(mon_e.is_ferr));
        end
      end
    end
    prev_valid = o_valid;
    prev_char  = o_char;
    prev_ferr  = o_frame_err;
  end

  // Must be entered exactly at a rising edge; returns at a rising edge.
  task automatic send_frame(input logic [7:0] b, input bit stop, input bit lat);
    exp_t e;
    #1 rx = 1'b0;
    e.is_ferr   = !stop;
    e.data      = b;
    e.lat_chk   = lat;
    e.start_cyc = cyc;
    exp_q.push_back(e);
    repeat (CPB) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1 rx = b[i];
      repeat (CPB) @(posedge clk);
    end
    #1 rx = stop;
    repeat (CPB) @(posedge clk);
    if (!stop) begin
      #1 rx = 1'b1;
    end
  endtask

  task automatic wait_valid(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (!o_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_cond(name, o_valid, n, "o_valid within 400 cycles");
  endtask

  task automatic do_ack();
    @(posedge clk);
    #1 ack = 1'b1;
    @(posedge clk);
    #1 ack = 1'b0;
    @(negedge clk);
  endtask

  int busy_cnt;

  initial begin
    rst_n = 1'b0;
    rx    = 1'b1;
    ack   = 1'b0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_char", int'(o_char), 0);
    check("rst_valid", int'(o_valid), 0);
    check("rst_frame_err", int'(o_frame_err), 0);
    check("rst_overrun", int'(o_overrun), 0);
    check("rst_busy", int'(o_busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) @(posedge clk);

    // Single byte 0xA5 with latency check, then ack
    send_frame(8'hA5, 1'b1, 1'b1);
    wait_valid("a5_valid_timeout");
    check("a5_char", int'(o_char), 8'hA5);
    check("a5_overrun", int'(o_overrun), 0);
    do_ack();
    check("a5_ack_valid", int'(o_valid), 0);

    // Glitch: 3 cycles low must not start a frame
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (3) @(posedge clk);
    #1 rx = 1'b1;
    busy_cnt = 0;
    repeat (30) begin
      @(negedge clk);
      if (o_busy) busy_cnt++;
    end
    check_cond("glitch_busy_len", (busy_cnt >= 1) && (busy_cnt <= 11), busy_cnt, "1..11");
    check("glitch_busy_end", int'(o_busy), 0);
    check("glitch_valid", int'(o_valid), 0);

    // Framing error: 0x3C with stop bit 0
    @(posedge clk);
    ferr_cnt = 0;
    send_frame(8'h3C, 1'b0, 1'b0);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("ferr_pulse_len", ferr_cnt, 1);
    check("ferr_valid", int'(o_valid), 0);
    check("ferr_char_kept", int'(o_char), 8'hA5);
    check("ferr_overrun", int'(o_overrun), 0);

    // Overrun: 0x11 then 0x22 back-to-back without ack
    @(posedge clk);
    send_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1, 1'b0);
    wait_valid("ovr_valid_timeout");
    repeat (4) @(negedge clk);
    check("ovr_char", int'(o_char), 8'h22);
    check("ovr_valid", int'(o_valid), 1);
    check("ovr_flag", int'(o_overrun), 1);
    do_ack();
    check("ovr_ack_valid", int'(o_valid), 0);
    check("ovr_ack_flag", int'(o_overrun), 0);

    // Reset during data bit 4 of 0xFF, then 0x5A
    @(posedge clk);
    #1 rx = 1'b0;
    repeat (CPB) @(posedge clk);
    #1 rx = 1'b1;
    repeat (CPB * 4 + CPB / 2) @(posedge clk);
    check("mid_busy_before_rst", int'(o_busy), 1);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_busy", int'(o_busy), 0);
    check("mid_rst_valid", int'(o_valid), 0);
    repeat (100) @(posedge clk);
    check("mid_no_byte", int'(o_valid), 0);
    @(posedge clk);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_valid("5a_valid_timeout");
    check("5a_char", int'(o_char), 8'h5A);
    check("5a_overrun", int'(o_overrun), 0);
    do_ack();
    check("5a_ack_valid", int'(o_valid), 0);

    repeat (20) @(posedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT, default 434, meaning clock cycles per bit (50 MHz / 115200), legal range 4..65535.
REQ-002 The block SHALL have port i_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-003 The block SHALL have port i_rst_n, input, 1 bit: the reset, which is synchronous and active-low.
REQ-004 The block SHALL have port i_rx, input, 1 bit: asynchronous serial line, idle high.
REQ-005 The block SHALL have port i_ack, input, 1 bit: consumer has taken o_char.
REQ-006 The block SHALL have port o_char, output, 8 bits: last received byte.
REQ-007 The block SHALL have port o_valid, output, 1 bit: o_char holds an unconsumed byte.
REQ-008 The block SHALL have port o_frame_err, output, 1 bit: one-cycle pulse on a bad stop bit.
REQ-009 The block SHALL have port o_overrun, output, 1 bit: sticky; a byte was lost.
REQ-010 The block SHALL have port o_busy, output, 1 bit: a frame is in progress (state != IDLE).

Function
REQ-011 Framing SHALL be 8N1: start bit 0, 8 data bits LSB first, 1 stop bit 1.
REQ-012 i_rx SHALL pass through a 2-flop synchronizer; a third flop holds the previous synchronized value for edge detection.
REQ-013 The bit counter SHALL be 16 bits; HALF = CLKS_PER_BIT/2, integer division.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP.
REQ-015 IDLE: on synchronized falling edge (prev=1, cur=0), go to START with cnt<=0; no other IDLE exit.
REQ-016 START: cnt increments; when cnt==HALF, sample; if 0, go to DATA with cnt<=0 and bit index<=0; if 1, treat as glitch and return to IDLE with no output change.
REQ-017 DATA: when cnt==CLKS_PER_BIT-1, sample and shift into the shift register at MSB (shift right), cnt<=0, bit index +1; after the 8th sample, go to STOP.
REQ-018 STOP: when cnt==CLKS_PER_BIT-1, sample and go to IDLE in all cases; a 0 pulses o_frame_err for one cycle and discards the byte.
REQ-019 On stop sample 1, the next cycle SHALL have o_char<=shift register and o_valid<=1.
REQ-020 Nominal latency from i_rx falling edge to o_valid rising SHALL be HALF+9*CLKS_PER_BIT+4 cycles, ±1.
REQ-021 i_ack with o_valid=1 SHALL clear o_valid and o_overrun the next cycle; i_ack with o_valid=0 SHALL be ignored.
REQ-022 On a byte load while o_valid=1 and i_ack=0: overwrite o_char, keep o_valid=1, set o_overrun=1.
REQ-023 On a byte load in the same cycle as i_ack: the load SHALL win; o_valid stays 1, o_overrun not set.
REQ-024 A frame with a bad stop bit SHALL not alter o_char, o_valid or o_overrun.
REQ-025 Back-to-back frames SHALL be accepted: a falling edge seen in the cycle after STOP exits SHALL start a new frame.

Reset
REQ-026 With i_rst_n=0 at a clock edge, the next state SHALL be: FSM=IDLE, cnt=0, shift register=0, o_char=0x00, o_valid=0, o_frame_err=0, o_overrun=0, o_busy=0, synchronizer flops=1.
REQ-027 Reset asserted mid-frame SHALL abandon the frame with no output; after release, a new start edge is required.

Verification (CLKS_PER_BIT=16, HALF=8)
REQ-028 Reset: hold i_rst_n=0 for 3 cycles with i_rx=1 -> all outputs 0, o_busy=0.
REQ-029 Single byte: send 0xA5 -> o_valid rises 156±1 cycles after start edge, o_char=0xA5, o_frame_err=0; i_ack -> o_valid=0 next cycle.
REQ-030 Glitch: i_rx low for 3 cycles, then high -> o_busy high for ≤11 cycles, then 0; o_valid stays 0.
REQ-031 Framing error: send 0x3C with stop bit 0 -> single-cycle o_frame_err; o_valid stays 0, o_char unchanged.
REQ-032 Overrun: send 0x11 then 0x22 back-to-back with no i_ack -> o_char=0x22, o_valid=1, o_overrun=1; i_ack -> both 0.
REQ-033 Reset mid-frame: assert i_rst_n=0 during data bit 4 of 0xFF, release, send 0x5A -> only 0x5A is delivered.
